// File: rtl/axi_apb_bridge_core.sv
// AXI4-Lite to APB4 protocol-conversion core: one APB transfer per AXI transaction, one outstanding.
// Optional ACCESS-phase timeout abort is enabled by defining AXI_APB_TIMEOUT_EN.
module axi_apb_bridge_core #(
    parameter int unsigned ADDRESS_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDRESS_WIDTH-1:0]  AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [ADDRESS_WIDTH-1:0]  ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [ADDRESS_WIDTH-1:0]  PADDR,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [DATA_WIDTH-1:0]     PWDATA,
    output logic [DATA_WIDTH/8-1:0]   PSTRB,
    input  logic [DATA_WIDTH-1:0]     PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WRESP,
        ST_RRESP
    } state_t;

    state_t state;
    logic   wr_prio;
    logic   wr_pend, rd_pend;
    logic   grant_wr, grant_rd;
    logic   xfer_done, xfer_err;
    logic [DATA_WIDTH-1:0] xfer_rdata;

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Ready is a pure function of state, valids and the alternating priority bit.
    always_comb begin
        wr_pend  = AWVALID && WVALID;
        rd_pend  = ARVALID;
        grant_wr = (state == ST_IDLE) && wr_pend && (!rd_pend || wr_prio);
        grant_rd = (state == ST_IDLE) && rd_pend && (!wr_pend || !wr_prio);
    end

    assign AWREADY = grant_wr;
    assign WREADY  = grant_wr;
    assign ARREADY = grant_rd;

`ifdef AXI_APB_TIMEOUT_EN
    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_WIDTH-1:0] wait_cnt;
    logic                 timed_out;

    // A timeout looks like a completion with SLVERR and zero read data.
    always_comb begin
        timed_out  = !PREADY && (wait_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
        xfer_done  = PREADY || timed_out;
        xfer_err   = !PREADY || PSLVERR;
        xfer_rdata = PREADY ? PRDATA : '0;
    end
`else
    always_comb begin
        xfer_done  = PREADY;
        xfer_err   = PSLVERR;
        xfer_rdata = PRDATA;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            wr_prio <= 1'b1;
            PADDR   <= '0;
            PWDATA  <= '0;
            PSTRB   <= '0;
            PWRITE  <= 1'b0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= '0;
            RVALID  <= 1'b0;
            RRESP   <= '0;
            RDATA   <= '0;
`ifdef AXI_APB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_wr) begin
                        PADDR   <= AWADDR;
                        PWDATA  <= WDATA;
                        PSTRB   <= WSTRB;
                        PWRITE  <= 1'b1;
                        PSEL    <= 1'b1;
                        wr_prio <= 1'b0;
                        state   <= ST_SETUP;
                    end else if (grant_rd) begin
                        PADDR   <= ARADDR;
                        PWDATA  <= '0;
                        PSTRB   <= '0;
                        PWRITE  <= 1'b0;
                        PSEL    <= 1'b1;
                        wr_prio <= 1'b1;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    PENABLE <= 1'b1;
`ifdef AXI_APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (xfer_done) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        if (PWRITE) begin
                            BRESP  <= xfer_err ? 2'b10 : 2'b00;
                            BVALID <= 1'b1;
                            state  <= ST_WRESP;
                        end else begin
                            RRESP  <= xfer_err ? 2'b10 : 2'b00;
                            RDATA  <= xfer_rdata;
                            RVALID <= 1'b1;
                            state  <= ST_RRESP;
                        end
                    end
`ifdef AXI_APB_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                ST_WRESP: begin
                    if (BREADY) begin
                        BVALID <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_RRESP: begin
                    if (RREADY) begin
                        RVALID <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_apb_bridge_core.sv
// Randomized self-checking bench for axi_apb_bridge_core against a transaction-level reference model.
// Honours AXI_APB_TIMEOUT_EN (timeout of 4 ACCESS cycles) when defined.
module tb_axi_apb_bridge_core;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TMO_CYC = 4;
`ifdef AXI_APB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] AWADDR;
    logic          AWVALID, AWREADY;
    logic [DW-1:0] WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID, WREADY;
    logic [1:0]    BRESP;
    logic          BVALID, BREADY;
    logic [AW-1:0] ARADDR;
    logic          ARVALID, ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID, RREADY;
    logic [AW-1:0] PADDR;
    logic          PSEL, PENABLE, PWRITE;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PSTRB;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model state: arbitration priority and last returned read data.
    bit            m_wr_prio;
    logic [DW-1:0] m_rdata;

    always #5 clk = ~clk;

    axi_apb_bridge_core #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TMO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One AXI transaction end to end. Entered and left at #1 after a rising edge with the DUT idle.
    task automatic xact(input bit want_wr, input bit want_rd,
                        input logic [AW-1:0] waddr, input logic [AW-1:0] raddr,
                        input logic [DW-1:0] wdata, input logic [3:0] strb,
                        input int unsigned waits, input bit err,
                        input logic [DW-1:0] prdata, input int unsigned rdly);
        bit            is_wr, aborted;
        int unsigned   n_acc;
        logic [AW-1:0] exp_addr;
        logic [1:0]    exp_resp;

        AWVALID = want_wr; WVALID = want_wr; AWADDR = waddr; WDATA = wdata; WSTRB = strb;
        ARVALID = want_rd; ARADDR = raddr;
        BREADY = 1'b0; RREADY = 1'b0;
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;

        is_wr     = want_wr && (!want_rd || m_wr_prio);
        m_wr_prio = !is_wr;
        exp_addr  = is_wr ? waddr : raddr;
        aborted   = TMO_EN && (waits >= TMO_CYC);
        n_acc     = aborted ? TMO_CYC : waits + 1;
        exp_resp  = (aborted || err) ? 2'b10 : 2'b00;

        @(negedge clk);
        check("awready_accept", AWREADY, is_wr);
        check("wready_accept", WREADY, is_wr);
        check("arready_accept", ARREADY, !is_wr);
        check("psel_idle", PSEL, 1'b0);

        next_cycle();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        AWADDR = $urandom; WDATA = $urandom; WSTRB = 4'($urandom); ARADDR = $urandom;
        PREADY = 1'($urandom); PSLVERR = 1'($urandom);
        @(negedge clk);
        check("setup_psel", PSEL, 1'b1);
        check("setup_penable", PENABLE, 1'b0);
        check("setup_paddr", PADDR, exp_addr);
        check("setup_pwrite", PWRITE, is_wr);
        check("setup_pstrb", PSTRB, is_wr ? strb : 4'h0);
        if (is_wr) check("setup_pwdata", PWDATA, wdata);

        for (int unsigned k = 0; k < n_acc; k++) begin
            next_cycle();
            PREADY  = (k == waits);
            PSLVERR = (k == waits) ? err : 1'($urandom);
            PRDATA  = (k == waits) ? prdata : $urandom;
            @(negedge clk);
            check("access_psel", PSEL, 1'b1);
            check("access_penable", PENABLE, 1'b1);
            check("access_paddr", PADDR, exp_addr);
            check("access_pwrite", PWRITE, is_wr);
            check("access_pstrb", PSTRB, is_wr ? strb : 4'h0);
            if (is_wr) check("access_pwdata", PWDATA, wdata);
            check("access_bvalid", BVALID, 1'b0);
            check("access_rvalid", RVALID, 1'b0);
        end

        next_cycle();
        PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
        if (!is_wr) m_rdata = aborted ? '0 : prdata;

        for (int unsigned j = 0; j <= rdly; j++) begin
            if (is_wr) begin
                BREADY = (j == rdly); RREADY = 1'($urandom);
            end else begin
                RREADY = (j == rdly); BREADY = 1'($urandom);
            end
            @(negedge clk);
            check("resp_psel", PSEL, 1'b0);
            check("resp_penable", PENABLE, 1'b0);
            check("resp_bvalid", BVALID, is_wr);
            check("resp_rvalid", RVALID, !is_wr);
            if (is_wr) check("resp_bresp", BRESP, exp_resp);
            else begin
                check("resp_rresp", RRESP, exp_resp);
                check("resp_rdata", RDATA, m_rdata);
            end
            if (j < rdly) next_cycle();
        end
        next_cycle();
        BREADY = 1'b0; RREADY = 1'b0;
    endtask

    // A write with only one of AWVALID/WVALID raised must not be accepted.
    task automatic partial_write();
        bit aw_only;
        aw_only = 1'($urandom);
        AWVALID = aw_only; WVALID = !aw_only; ARVALID = 1'b0;
        @(negedge clk);
        check("partial_awready", AWREADY, 1'b0);
        check("partial_wready", WREADY, 1'b0);
        check("partial_arready", ARREADY, 1'b0);
        check("partial_psel", PSEL, 1'b0);
        next_cycle();
        AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        m_wr_prio = 1'b1;
        m_rdata   = '0;
        repeat (3) next_cycle();
        rst = 1'b0;

        @(negedge clk);
        check("rst_awready", AWREADY, 1'b0);
        check("rst_arready", ARREADY, 1'b0);
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_pstrb", PSTRB, 4'h0);
        check("rst_bvalid", BVALID, 1'b0);
        check("rst_bresp", BRESP, 2'b00);
        check("rst_rvalid", RVALID, 1'b0);
        check("rst_rresp", RRESP, 2'b00);
        check("rst_rdata", RDATA, 32'h0);
        next_cycle();

        // Simultaneous requests twice after reset: write first, then read.
        xact(1'b1, 1'b1, 32'h10, 32'h20, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 0);
        xact(1'b1, 1'b1, 32'h10, 32'h20, 32'h0, 4'hF, 2, 1'b0, 32'h12345678, 3);
        xact(1'b1, 1'b0, 32'h44, 32'h0, 32'hA5A5A5A5, 4'h3, 1, 1'b1, 32'h0, 0);
        xact(1'b0, 1'b1, 32'h0, 32'h48, 32'h0, 4'h0, 0, 1'b1, 32'hCAFEF00D, 1);
        xact(1'b0, 1'b1, 32'h0, 32'h4C, 32'h0, 4'h0, 100, 1'b0, 32'h0BADBEEF, 0);
        xact(1'b0, 1'b1, 32'h0, 32'h50, 32'h0, 4'h0, TMO_CYC - 1, 1'b0, 32'h13579BDF, 0);

        for (int i = 0; i < 60; i++) begin
            int unsigned sel;
            if ($urandom_range(0, 3) == 0) partial_write();
            sel = $urandom_range(1, 3);
            xact(sel[0], sel[1], $urandom, $urandom, $urandom, 4'($urandom),
                 $urandom_range(0, 5), 1'($urandom), $urandom, $urandom_range(0, 3));
        end

        // Reset during ACCESS of a write, then confirm write priority is restored.
        AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b0; AWADDR = 32'h60; WDATA = 32'h1; WSTRB = 4'hF;
        m_wr_prio = 1'b0;
        next_cycle();
        AWVALID = 1'b0; WVALID = 1'b0; PREADY = 1'b0;
        next_cycle();
        @(negedge clk);
        check("pre_rst_penable", PENABLE, 1'b1);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        m_wr_prio = 1'b1;
        m_rdata   = '0;
        @(negedge clk);
        check("midrst_psel", PSEL, 1'b0);
        check("midrst_penable", PENABLE, 1'b0);
        check("midrst_bvalid", BVALID, 1'b0);
        check("midrst_rvalid", RVALID, 1'b0);
        next_cycle();
        xact(1'b1, 1'b1, 32'h70, 32'h74, 32'h77777777, 4'h5, 0, 1'b0, 32'h0, 0);
        xact(1'b1, 1'b1, 32'h70, 32'h74, 32'h0, 4'h0, 0, 1'b0, 32'h88888888, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
